axi_sram_slave: RTL

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

---
 rtl/axi_sram_slave.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/axi_sram_slave.sv
// AXI3-style single-port SRAM slave: one outstanding burst, round-robin AR/AW arbitration.
// Storage is 2^MEM_AW 32-bit words; upper address bits alias.
module axi_sram_slave #(
   parameter int MEM_AW         = 10,
   parameter int INIT_PRIO_READ = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  arid,
   input  logic [31:0] araddr,
   input  logic [3:0]  arlen,
   input  logic [1:0]  arburst,
   input  logic        arvalid,
   output logic        arready,
   output logic [3:0]  rid,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rlast,
   output logic        rvalid,
   input  logic        rready,
   input  logic [3:0]  awid,
   input  logic [31:0] awaddr,
   input  logic [3:0]  awlen,
   input  logic [1:0]  awburst,
   input  logic        awvalid,
   output logic        awready,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wlast,
   input  logic        wvalid,
   output logic        wready,
   output logic [3:0]  bid,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready
);

   localparam int DEPTH = 1 << MEM_AW;

   typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_WRESP} state_t;

   state_t      state, state_nxt;
   logic [31:0] mem [DEPTH];
   logic        prio_read;
   logic [31:0] addr, addr_nxt, wrap_mask;
   logic [3:0]  len, beat;
   logic [1:0]  burst;
   logic        ar_hs, aw_hs, w_hs, r_hs;
   logic        ar_bad, aw_bad;

   // Reserved burst or illegal WRAP length degrades to INCR with SLVERR.
   function automatic logic bad_burst(input logic [3:0] l, input logic [1:0] b);
      return (b == 2'b11) ||
             (b == 2'b10 && !(l == 4'd1 || l == 4'd3 || l == 4'd7 || l == 4'd15));
   endfunction

   assign ar_bad = bad_burst(arlen, arburst);
   assign aw_bad = bad_burst(awlen, awburst);
   assign ar_hs  = arvalid && arready;
   assign aw_hs  = awvalid && awready;
   assign w_hs   = wvalid && wready;
   assign r_hs   = rvalid && rready;

   always_comb begin
      wrap_mask = {26'd0, len, 2'b11};
      case (burst)
         2'b00:   addr_nxt = addr;
         2'b10:   addr_nxt = (addr & ~wrap_mask) | ((addr + 32'd4) & wrap_mask);
         default: addr_nxt = addr + 32'd4;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (ar_hs)      state_nxt = S_RD;
            else if (aw_hs) state_nxt = S_WR;
         end
         S_RD:    if (r_hs && rlast)          state_nxt = S_IDLE;
         S_WR:    if (w_hs && (beat == len))  state_nxt = S_WRESP;
         S_WRESP: if (bready)                 state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      arready = !rst && (state == S_IDLE) && arvalid && (!awvalid || prio_read);
      awready = !rst && (state == S_IDLE) && awvalid && (!arvalid || !prio_read);
      wready  = (state == S_WR);
      rvalid  = (state == S_RD);
      bvalid  = (state == S_WRESP);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prio_read <= (INIT_PRIO_READ != 0);
         addr      <= '0;
         len       <= '0;
         burst     <= '0;
         beat      <= '0;
         rid       <= '0;
         rdata     <= '0;
         rresp     <= '0;
         rlast     <= 1'b0;
         bid       <= '0;
         bresp     <= '0;
      end else begin
         if (state == S_IDLE && arvalid && awvalid)
            prio_read <= !prio_read;
         if (ar_hs) begin
            rid   <= arid;
            addr  <= araddr;
            len   <= arlen;
            burst <= ar_bad ? 2'b01 : arburst;
            beat  <= '0;
            rresp <= ar_bad ? 2'b10 : 2'b00;
            rlast <= (arlen == 4'd0);
            rdata <= mem[araddr[MEM_AW+1:2]];
         end else if (aw_hs) begin
            bid   <= awid;
            addr  <= awaddr;
            len   <= awlen;
            burst <= aw_bad ? 2'b01 : awburst;
            beat  <= '0;
            bresp <= aw_bad ? 2'b10 : 2'b00;
         end
         if (r_hs) begin
            if (rlast) begin
               rlast <= 1'b0;
            end else begin
               addr  <= addr_nxt;
               beat  <= beat + 4'd1;
               rlast <= ((beat + 4'd1) == len);
               rdata <= mem[addr_nxt[MEM_AW+1:2]];
            end
         end
         // Burst length comes from the beat count; wlast only grades the response.
         if (w_hs) begin
            addr <= addr_nxt;
            beat <= beat + 4'd1;
            if (wlast != (beat == len))
               bresp <= 2'b10;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_hs) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (wstrb[i])
               mem[addr[MEM_AW+1:2]][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

endmodule
